uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Bus initiator for the memory-mapped peripheral bus.
- Consumes command bytes from the UART receiver and issues single-word rd/wr transactions on the peripheral bus.
- Returns read data or status bytes to the UART sender.
- Used as a host-side debug/loader port: the PC pokes timer, LED, digit and UART registers without the CPU running.

Parameters:
- TIMEOUT_CYCLES, 1000000, max clk cycles allowed between bytes of one command before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte, valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- tx_data  out  8  byte to send.
- tx_valid  out  1  tx_data is valid; byte is taken on a cycle with tx_valid&tx_ready.
- tx_ready  in  1  sender can accept a byte.
- rd  out  1  bus read strobe.
- wr  out  1  bus write strobe.
- addr  out  32  bus address.
- wdata  out  32  bus write data.
- rdata  in  32  bus read data; combinational from the slave, valid in the same cycle rd=1.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when a byte arrives in a state that cannot accept it; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state=IDLE; rd=wr=0; addr=wdata=0; tx_data=0; tx_valid=0; overrun=0; byte index=0; timeout counter=0. Reset mid-command or mid-reply abandons it immediately; no further tx bytes.
- Protocol is big-endian, MSB byte first:
  - Read: 0x52, A3..A0 -> reply D3..D0.
  - Write: 0x57, A3..A0, D3..D0 -> reply 0x4B.
  - Other command byte -> reply 0x3F.
  - Address with addr[1:0]!=0 -> reply 0x3F, no bus access.
  - Timeout -> reply 0x54.
- States:
  - IDLE: on rx_valid, decode the byte. 0x52 -> ADDR (op=read). 0x57 -> ADDR (op=write). Else load reply 0x3F and go to RESP.
  - ADDR: shift in 4 bytes into addr (addr <= {addr[23:0], rx_data}). After the 4th byte: if misaligned, reply 0x3F -> RESP. Else read -> BUS_RD, write -> DATA.
  - DATA: shift in 4 bytes into wdata. After the 4th byte -> BUS_WR.
  - BUS_RD: rd=1 for exactly this one cycle. Capture rdata into the reply shift register in the same cycle. Reply length=4 -> RESP.
  - BUS_WR: wr=1 for exactly one cycle with addr/wdata stable. Reply=0x4B, length=1 -> RESP.
  - RESP: present bytes MSB first. tx_valid=1 with tx_data stable until tx_ready. On handshake, advance to the next byte. After the last byte, tx_valid=0 next cycle -> IDLE.
- Latency:
  - rd/wr asserts the cycle after the last command byte's rx_valid.
  - tx_valid asserts the cycle after the rd/wr cycle.
- rd and wr are never both high. Both are 0 outside BUS_RD/BUS_WR. addr and wdata hold their last value between transactions.
- Timeout:
  - In ADDR/DATA, the counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES: reply 0x54 -> RESP, and the partial command is discarded.
  - The counter is idle (0) in all other states.
- rx_valid in BUS_RD, BUS_WR or RESP: byte dropped, overrun<=1, state unaffected.
- rx_valid on the same cycle as a timeout expiry: the byte wins, the counter clears, and the command continues.
- tx_ready held low indefinitely: block stays in RESP with tx_data/tx_valid stable. Timeout is not applied in RESP.

Decomposition:
- Shared package uart_bus_pkg holds:
  - Command/status constants CMD_READ=8'h52, CMD_WRITE=8'h57, RSP_ACK=8'h4B, RSP_ERR=8'h3F, RSP_TMO=8'h54.
  - State enum (IDLE, ADDR, DATA, BUS_RD, BUS_WR, RESP).
- One sub-module, uart_bus_reply: 32-bit reply shift register plus 3-bit length counter, implementing the tx valid/ready handshake. The FSM loads it; it reports done.

Test Plan:
- Read: rx bytes 52 40 00 00 10, slave rdata=0x000000A5 -> exactly one rd cycle with addr=0x40000010, wr=0; tx bytes 00 00 00 A5; busy falls after the last handshake.
- Write: rx 57 40 00 00 0C 00 00 00 FF -> exactly one wr cycle with addr=0x4000000C, wdata=0x000000FF; single tx byte 4B.
- Errors:
  - rx 00 -> tx 3F, no rd/wr.
  - rx 52 40 00 00 11 -> tx 3F, no rd.
  - TIMEOUT_CYCLES=16: rx 52 40 00 then 16 idle cycles -> tx 54, back to IDLE; a following full read succeeds.
- Backpressure/overrun:
  - Read with tx_ready low for 50 cycles, then pulsed -> each byte held stable until taken, order D3..D0.
  - A byte injected during RESP -> overrun=1 and the reply is unchanged.
- Reset mid-reply: assert reset after 2 of 4 read bytes are sent -> next cycle tx_valid=0, rd=wr=0, busy=0, overrun=0; a subsequent write command completes normally.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared command/status codes and FSM state encoding for the UART bus master.
package uart_bus_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_RD,
    BUS_WR,
    RESP
  } state_e;

endpackage

// File: rtl/uart_bus_master_reply.sv
// Reply shifter: holds up to four bytes and hands them to the UART sender
// MSB first over a valid/ready handshake, flagging the final byte's transfer.
module uart_bus_reply (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic [2:0]  load_len_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        done_o
);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  len_q, len_d;

  assign tx_data_o  = shift_q[31:24];
  assign tx_valid_o = (len_q != 3'd0);
  assign done_o     = tx_valid_o && tx_ready_i && (len_q == 3'd1);

  always_comb begin
    shift_d = shift_q;
    len_d   = len_q;
    if (load_i) begin
      shift_d = load_data_i;
      len_d   = load_len_i;
    end else if (tx_valid_o && tx_ready_i) begin
      shift_d = {shift_q[23:0], 8'h00};
      len_d   = len_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      len_q   <= '0;
    end else begin
      shift_q <= shift_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Host-side debug port: turns UART command bytes into single-word bus reads
// and writes, and returns read data or a status byte.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic            write_q, write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            overrun_q, overrun_d;

  logic            load;
  logic [31:0]     load_data;
  logic [2:0]      load_len;
  logic            reply_done;

  uart_bus_reply u_reply (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_data_i(load_data),
    .load_len_i (load_len),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .done_o     (reply_done)
  );

  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

  // A byte arriving on the expiry cycle wins: the timeout only fires on a quiet cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_d     = '0;
    overrun_d = overrun_q;
    load      = 1'b0;
    load_data = '0;
    load_len  = '0;
    rd        = 1'b0;
    wr        = 1'b0;

    if ((state_q == ADDR || state_q == DATA) && !rx_valid)
      tmo_d = tmo_q + 1'b1;

    if (rx_valid && (state_q == BUS_RD || state_q == BUS_WR || state_q == RESP))
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          idx_d = 2'd0;
          if (rx_data == CMD_READ) begin
            write_d = 1'b0;
            state_d = ADDR;
          end else if (rx_data == CMD_WRITE) begin
            write_d = 1'b1;
            state_d = ADDR;
          end else begin
            load      = 1'b1;
            load_data = {RSP_ERR, 24'h0};
            load_len  = 3'd1;
            state_d   = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (addr_d[1:0] != 2'b00) begin
              load      = 1'b1;
              load_data = {RSP_ERR, 24'h0};
              load_len  = 3'd1;
              state_d   = RESP;
            end else begin
              state_d = write_q ? DATA : BUS_RD;
            end
          end
        end else if (tmo_d == TMO_LIMIT) begin
          load      = 1'b1;
          load_data = {RSP_TMO, 24'h0};
          load_len  = 3'd1;
          state_d   = RESP;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_data};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = BUS_WR;
        end else if (tmo_d == TMO_LIMIT) begin
          load      = 1'b1;
          load_data = {RSP_TMO, 24'h0};
          load_len  = 3'd1;
          state_d   = RESP;
        end
      end
      BUS_RD: begin
        rd        = 1'b1;
        load      = 1'b1;
        load_data = rdata;
        load_len  = 3'd4;
        state_d   = RESP;
      end
      BUS_WR: begin
        wr        = 1'b1;
        load      = 1'b1;
        load_data = {RSP_ACK, 24'h0};
        load_len  = 3'd1;
        state_d   = RESP;
      end
      RESP: begin
        if (reply_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: expected tx bytes are queued as commands
// are sent and popped as the sender accepts them; bus strobes are checked as they occur.
module tb_uart_bus_master;
  import uart_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        overrun;

  logic [31:0] slaveWord;
  logic [31:0] expAddr;
  logic [31:0] expWdata;
  logic [7:0]  expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          rdSeen      = 0;
  int          wrSeen      = 0;

  always #5 clk = ~clk;

  // Slave model: read data is combinational while rd is high.
  assign rdata = rd ? slaveWord : 32'h0;

  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitors sample on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        if (expQ.size() == 0)
          checkOutput("tx unexpected byte", {24'h0, tx_data}, 32'h100);
        else
          checkOutput("tx byte", {24'h0, tx_data}, {24'h0, expQ.pop_front()});
      end
      if (rd || wr)
        checkOutput("rd/wr exclusive", 32'(rd & wr), 32'd0);
      if (rd) begin
        rdSeen++;
        checkOutput("rd addr", addr, expAddr);
      end
      if (wr) begin
        wrSeen++;
        checkOutput("wr addr", addr, expAddr);
        checkOutput("wr data", wdata, expWdata);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++)
      sendByte(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic pushWord(input logic [31:0] w);
    expQ.push_back(w[31:24]);
    expQ.push_back(w[23:16]);
    expQ.push_back(w[15:8]);
    expQ.push_back(w[7:0]);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulseReady(input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("tx_valid before pulse", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
  endtask

  task automatic clearCounts();
    rdSeen = 0;
    wrSeen = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tx_ready  = 1'b1;
    slaveWord = 32'h0;
    expAddr   = 32'h0;
    expWdata  = 32'h0;
    tick(3);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset tx_data", {24'h0, tx_data}, 32'd0);
    checkOutput("reset rd/wr", {30'h0, rd, wr}, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset addr", addr, 32'd0);
    reset = 1'b0;
    tick(2);

    $display("[TB] read 0x40000010");
    clearCounts();
    expAddr   = 32'h4000_0010;
    slaveWord = 32'h0000_00A5;
    pushWord(slaveWord);
    applyStimulus({8'h52, 32'h4000_0010}, 5);
    checkOutput("rd latency", 32'(rd), 32'd1);
    tick(1);
    checkOutput("tx_valid latency", 32'(tx_valid), 32'd1);
    waitIdle("read done", 50);
    checkOutput("read rd count", 32'(rdSeen), 32'd1);
    checkOutput("read wr count", 32'(wrSeen), 32'd0);
    checkOutput("read reply drained", 32'(expQ.size()), 32'd0);

    $display("[TB] write 0x4000000C <- 0xFF");
    clearCounts();
    expAddr  = 32'h4000_000C;
    expWdata = 32'h0000_00FF;
    expQ.push_back(RSP_ACK);
    applyStimulus({8'h57, 32'h4000_000C, 32'h0000_00FF}, 9);
    checkOutput("wr latency", 32'(wr), 32'd1);
    waitIdle("write done", 50);
    checkOutput("write wr count", 32'(wrSeen), 32'd1);
    checkOutput("write rd count", 32'(rdSeen), 32'd0);

    $display("[TB] bad command and misaligned address");
    clearCounts();
    expQ.push_back(RSP_ERR);
    sendByte(8'h00);
    waitIdle("bad cmd done", 50);
    expQ.push_back(RSP_ERR);
    applyStimulus({8'h52, 32'h4000_0011}, 5);
    checkOutput("misaligned no rd", 32'(rd), 32'd0);
    waitIdle("misaligned done", 50);
    checkOutput("error bus accesses", 32'(rdSeen + wrSeen), 32'd0);

    $display("[TB] timeout then read");
    clearCounts();
    expQ.push_back(RSP_TMO);
    applyStimulus({8'h52, 8'h40, 8'h00}, 3);
    tick(15);
    checkOutput("pre-timeout busy", 32'(busy), 32'd1);
    checkOutput("pre-timeout tx_valid", 32'(tx_valid), 32'd0);
    waitIdle("timeout done", 20);
    checkOutput("timeout reply drained", 32'(expQ.size()), 32'd0);
    checkOutput("timeout no rd", 32'(rdSeen), 32'd0);
    expAddr   = 32'h4000_0020;
    slaveWord = 32'h0BAD_F00D;
    pushWord(slaveWord);
    applyStimulus({8'h52, 32'h4000_0020}, 5);
    waitIdle("post-timeout read done", 50);
    checkOutput("post-timeout rd count", 32'(rdSeen), 32'd1);

    $display("[TB] backpressure and overrun");
    clearCounts();
    tx_ready  = 1'b0;
    expAddr   = 32'h4000_0004;
    slaveWord = 32'h1234_5678;
    pushWord(slaveWord);
    applyStimulus({8'h52, 32'h4000_0004}, 5);
    tick(25);
    checkOutput("stall tx_valid", 32'(tx_valid), 32'd1);
    checkOutput("stall tx_data", {24'h0, tx_data}, 32'h12);
    sendByte(8'h57);
    checkOutput("overrun set", 32'(overrun), 32'd1);
    checkOutput("overrun busy", 32'(busy), 32'd1);
    tick(25);
    checkOutput("stall tx_data held", {24'h0, tx_data}, 32'h12);
    for (int i = 0; i < 4; i++) begin
      pulseReady(10);
      tick(3);
    end
    waitIdle("backpressure done", 20);
    checkOutput("backpressure drained", 32'(expQ.size()), 32'd0);

    $display("[TB] reset mid-reply then write");
    clearCounts();
    expAddr   = 32'h4000_0008;
    slaveWord = 32'hCAFE_F00D;
    pushWord(slaveWord);
    applyStimulus({8'h52, 32'h4000_0008}, 5);
    pulseReady(10);
    pulseReady(10);
    checkOutput("mid-reply pending", 32'(expQ.size()), 32'd2);
    expQ.delete();
    reset = 1'b1;
    tick(1);
    checkOutput("mid-reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("mid-reset rd/wr", {30'h0, rd, wr}, 32'd0);
    checkOutput("mid-reset busy", 32'(busy), 32'd0);
    checkOutput("mid-reset overrun", 32'(overrun), 32'd0);
    reset    = 1'b0;
    tx_ready = 1'b1;
    tick(2);
    clearCounts();
    expAddr  = 32'h4000_0000;
    expWdata = 32'h0000_0055;
    expQ.push_back(RSP_ACK);
    applyStimulus({8'h57, 32'h4000_0000, 32'h0000_0055}, 9);
    waitIdle("post-reset write done", 50);
    checkOutput("post-reset wr count", 32'(wrSeen), 32'd1);

    tick(2);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
